// File: rtl/forwarding_scoreboard_if.sv
// Decode-side bundle for the forwarding scoreboard: ID operands and pipeline
// control in, bypass selects and stall/occupancy status out.
interface forwarding_scoreboard_if #(
    parameter int ADDR_W = 5,
    parameter int STAGES = 3,
    parameter int CNT_W  = 16
);
    localparam int SEL_W = $clog2(STAGES + 1);

    logic              fwd_id_valid_in;
    logic [ADDR_W-1:0] fwd_id_rd_addr_in;
    logic              fwd_id_rd_wen_in;
    logic              fwd_id_is_load_in;
    logic [ADDR_W-1:0] fwd_id_ra_addr_in;
    logic [ADDR_W-1:0] fwd_id_rb_addr_in;
    logic              fwd_hold_in;
    logic              fwd_flush_in;
    logic [SEL_W-1:0]  fwd_ra_sel_out;
    logic [SEL_W-1:0]  fwd_rb_sel_out;
    logic              fwd_stall_out;
    logic [CNT_W-1:0]  fwd_stall_cnt_out;
    logic              fwd_busy_out;

    modport master (
        output fwd_id_valid_in, fwd_id_rd_addr_in, fwd_id_rd_wen_in, fwd_id_is_load_in,
               fwd_id_ra_addr_in, fwd_id_rb_addr_in, fwd_hold_in, fwd_flush_in,
        input  fwd_ra_sel_out, fwd_rb_sel_out, fwd_stall_out, fwd_stall_cnt_out, fwd_busy_out
    );

    modport slave (
        input  fwd_id_valid_in, fwd_id_rd_addr_in, fwd_id_rd_wen_in, fwd_id_is_load_in,
               fwd_id_ra_addr_in, fwd_id_rb_addr_in, fwd_hold_in, fwd_flush_in,
        output fwd_ra_sel_out, fwd_rb_sel_out, fwd_stall_out, fwd_stall_cnt_out, fwd_busy_out
    );
endinterface

// File: rtl/forwarding_scoreboard.sv
// Tracks destinations of in-flight instructions (entry 0 = EX, last = WB), picks the
// youngest bypass source per ID operand and requests a stall on an unready load.
module forwarding_scoreboard #(
    parameter int ADDR_W     = 5,
    parameter int STAGES     = 3,
    parameter int LOAD_RDY   = 1,
    parameter int KILL_DEPTH = 1,
    parameter int CNT_W      = 16
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    forwarding_scoreboard_if.slave fwd
);
    localparam int SEL_W = $clog2(STAGES + 1);

    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] wen_q, wen_d;
    logic [STAGES-1:0] ld_q, ld_d;
    logic [ADDR_W-1:0] rd_q [STAGES];
    logic [ADDR_W-1:0] rd_d [STAGES];
    logic [CNT_W-1:0]  cnt_q;

    logic [SEL_W-1:0]  ra_sel, rb_sel;
    logic              ra_rdy, rb_rdy;
    logic              stall;

    // Scan oldest to youngest so the youngest matching producer is the one left standing.
    always_comb begin
        ra_sel = '0;
        rb_sel = '0;
        ra_rdy = 1'b1;
        rb_rdy = 1'b1;
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (vld_q[k] && wen_q[k] && fwd.fwd_id_ra_addr_in != '0 &&
                rd_q[k] == fwd.fwd_id_ra_addr_in) begin
                ra_sel = SEL_W'(k + 1);
                ra_rdy = !ld_q[k] || (k >= LOAD_RDY);
            end
            if (vld_q[k] && wen_q[k] && fwd.fwd_id_rb_addr_in != '0 &&
                rd_q[k] == fwd.fwd_id_rb_addr_in) begin
                rb_sel = SEL_W'(k + 1);
                rb_rdy = !ld_q[k] || (k >= LOAD_RDY);
            end
        end
        stall = fwd.fwd_id_valid_in && (!ra_rdy || !rb_rdy);
    end

    always_comb begin
        vld_d = vld_q;
        wen_d = wen_q;
        ld_d  = ld_q;
        rd_d  = rd_q;
        if (!fwd.fwd_hold_in) begin
            for (int k = STAGES - 1; k > 0; k--) begin
                vld_d[k] = vld_q[k-1];
                wen_d[k] = wen_q[k-1];
                ld_d[k]  = ld_q[k-1];
                rd_d[k]  = rd_q[k-1];
            end
            // A stalled or flushed ID slot enters the pipe as a bubble.
            vld_d[0] = fwd.fwd_id_valid_in && !stall && !fwd.fwd_flush_in;
            wen_d[0] = fwd.fwd_id_rd_wen_in && (fwd.fwd_id_rd_addr_in != '0);
            ld_d[0]  = fwd.fwd_id_is_load_in;
            rd_d[0]  = fwd.fwd_id_rd_addr_in;
        end
        if (fwd.fwd_flush_in) begin
            for (int k = 0; k < KILL_DEPTH; k++) begin
                vld_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            vld_q <= '0;
            cnt_q <= '0;
        end else begin
            vld_q <= vld_d;
            if (stall && !fwd.fwd_hold_in && cnt_q != '1) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Payload fields are qualified by vld_q, so they need no reset.
    always_ff @(posedge clk_in) begin
        wen_q <= wen_d;
        ld_q  <= ld_d;
        rd_q  <= rd_d;
    end

    assign fwd.fwd_ra_sel_out    = ra_sel;
    assign fwd.fwd_rb_sel_out    = rb_sel;
    assign fwd.fwd_stall_out     = stall;
    assign fwd.fwd_stall_cnt_out = cnt_q;
    assign fwd.fwd_busy_out      = |vld_q;
endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Directed bench for forwarding_scoreboard: expectations are queued as each step is
// driven and popped when the outputs are sampled mid-cycle.
module tb_forwarding_scoreboard;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    forwarding_scoreboard_if #(.ADDR_W(5), .STAGES(3), .CNT_W(16)) bus ();
    forwarding_scoreboard_if #(.ADDR_W(5), .STAGES(3), .CNT_W(4))  sbus ();

    forwarding_scoreboard #(
        .ADDR_W(5), .STAGES(3), .LOAD_RDY(1), .KILL_DEPTH(1), .CNT_W(16)
    ) dut (
        .clk_in(clk), .rst_in(rst), .fwd(bus)
    );

    forwarding_scoreboard #(
        .ADDR_W(5), .STAGES(3), .LOAD_RDY(1), .KILL_DEPTH(1), .CNT_W(4)
    ) dut_sat (
        .clk_in(clk), .rst_in(rst), .fwd(sbus)
    );

    typedef struct {
        string       tag;
        logic [1:0]  ra;
        logic [1:0]  rb;
        logic        stall;
        logic [15:0] cnt;
        logic        busy;
    } exp_t;

    exp_t sb[$];
    int vectors     = 0;
    int miscompares = 0;

    task automatic drive(input logic v, input logic [4:0] rd, input logic wen, input logic ld,
                         input logic [4:0] ra, input logic [4:0] rb,
                         input logic hold, input logic flush);
        bus.fwd_id_valid_in   = v;
        bus.fwd_id_rd_addr_in = rd;
        bus.fwd_id_rd_wen_in  = wen;
        bus.fwd_id_is_load_in = ld;
        bus.fwd_id_ra_addr_in = ra;
        bus.fwd_id_rb_addr_in = rb;
        bus.fwd_hold_in       = hold;
        bus.fwd_flush_in      = flush;
    endtask

    task automatic expect_out(input string tag, input logic [1:0] ra, input logic [1:0] rb,
                              input logic st, input logic [15:0] cnt, input logic busy);
        exp_t e;
        e.tag = tag; e.ra = ra; e.rb = rb; e.stall = st; e.cnt = cnt; e.busy = busy;
        sb.push_back(e);
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_empty: got 0 entries expected at least 1");
            return;
        end
        e = sb.pop_front();
        vectors++;
        assert (bus.fwd_ra_sel_out === e.ra) else begin
            miscompares++;
            $error("FAIL %s ra_sel: got %0d expected %0d", e.tag, bus.fwd_ra_sel_out, e.ra);
        end
        vectors++;
        assert (bus.fwd_rb_sel_out === e.rb) else begin
            miscompares++;
            $error("FAIL %s rb_sel: got %0d expected %0d", e.tag, bus.fwd_rb_sel_out, e.rb);
        end
        vectors++;
        assert (bus.fwd_stall_out === e.stall) else begin
            miscompares++;
            $error("FAIL %s stall: got %0b expected %0b", e.tag, bus.fwd_stall_out, e.stall);
        end
        vectors++;
        assert (bus.fwd_stall_cnt_out === e.cnt) else begin
            miscompares++;
            $error("FAIL %s cnt: got %0d expected %0d", e.tag, bus.fwd_stall_cnt_out, e.cnt);
        end
        vectors++;
        assert (bus.fwd_busy_out === e.busy) else begin
            miscompares++;
            $error("FAIL %s busy: got %0b expected %0b", e.tag, bus.fwd_busy_out, e.busy);
        end
    endtask

    // Drive, queue the expectation, let combinational outputs settle, then check.
    task automatic step(input logic v, input logic [4:0] rd, input logic wen, input logic ld,
                        input logic [4:0] ra, input logic [4:0] rb,
                        input logic hold, input logic flush,
                        input string tag, input logic [1:0] e_ra, input logic [1:0] e_rb,
                        input logic e_st, input logic [15:0] e_cnt, input logic e_busy);
        drive(v, rd, wen, ld, ra, rb, hold, flush);
        expect_out(tag, e_ra, e_rb, e_st, e_cnt, e_busy);
        #3;
        compare_out();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        repeat (n) tick();
    endtask

    task automatic check_sat(input string tag, input logic [3:0] exp_cnt);
        vectors++;
        assert (sbus.fwd_stall_cnt_out === exp_cnt) else begin
            miscompares++;
            $error("FAIL %s cnt: got %0d expected %0d", tag, sbus.fwd_stall_cnt_out, exp_cnt);
        end
    endtask

    initial begin
        rst = 1'b1;
        sbus.fwd_id_valid_in   = 1'b0;
        sbus.fwd_id_rd_addr_in = '0;
        sbus.fwd_id_rd_wen_in  = 1'b0;
        sbus.fwd_id_is_load_in = 1'b0;
        sbus.fwd_id_ra_addr_in = '0;
        sbus.fwd_id_rb_addr_in = '0;
        sbus.fwd_hold_in       = 1'b0;
        sbus.fwd_flush_in      = 1'b0;
        step(0, 0, 0, 0, 0, 0, 0, 0, "reset", 0, 0, 0, 0, 0);
        #4 rst = 1'b0;
        tick();

        // ALU chain
        step(1, 5, 1, 0, 0, 0, 0, 0, "alu_issue", 0, 0, 0, 0, 0);  tick();
        step(0, 0, 0, 0, 5, 0, 0, 0, "alu_ex",    1, 0, 0, 0, 1);  tick();
        step(0, 0, 0, 0, 5, 0, 0, 0, "alu_mem",   2, 0, 0, 0, 1);  tick();
        step(0, 0, 0, 0, 5, 0, 0, 0, "alu_wb",    3, 0, 0, 0, 1);  tick();
        step(0, 0, 0, 0, 5, 0, 0, 0, "alu_gone",  0, 0, 0, 0, 0);

        // Youngest producer wins
        step(1, 7, 1, 0, 0, 0, 0, 0, "yw_issue1", 0, 0, 0, 0, 0);  tick();
        step(1, 7, 1, 0, 0, 0, 0, 0, "yw_issue2", 0, 0, 0, 0, 1);  tick();
        step(0, 0, 0, 0, 7, 7, 0, 0, "yw_sel",    1, 1, 0, 0, 1);
        idle(3);

        // Load-use on source A, then on source B
        step(1, 3, 1, 1, 0, 0, 0, 0, "lu_issue",   0, 0, 0, 0, 0);  tick();
        step(1, 10, 1, 0, 3, 0, 0, 0, "lu_stall",  1, 0, 1, 0, 1);  tick();
        step(1, 10, 1, 0, 3, 0, 0, 0, "lu_fwd",    2, 0, 0, 1, 1);  tick();
        idle(3);
        step(1, 3, 1, 1, 0, 0, 0, 0, "lub_issue",  0, 0, 0, 1, 0);  tick();
        step(1, 10, 1, 0, 4, 3, 0, 0, "lub_stall", 0, 1, 1, 1, 1);  tick();
        step(1, 10, 1, 0, 4, 3, 0, 0, "lub_fwd",   0, 2, 0, 2, 1);  tick();
        idle(3);

        // x0 never forwards
        step(1, 0, 1, 0, 0, 0, 0, 0, "x0_issue", 0, 0, 0, 2, 0);  tick();
        step(0, 0, 0, 0, 0, 0, 0, 0, "x0_read",  0, 0, 0, 2, 1);
        idle(3);

        // Hold then flush
        step(1, 1, 1, 0, 0, 0, 0, 0, "hf_i1", 0, 0, 0, 2, 0);  tick();
        step(1, 2, 1, 0, 0, 0, 0, 0, "hf_i2", 0, 0, 0, 2, 1);  tick();
        step(1, 3, 1, 0, 0, 0, 0, 0, "hf_i3", 0, 0, 0, 2, 1);  tick();
        step(0, 0, 0, 0, 1, 0, 1, 0, "hold0", 3, 0, 0, 2, 1);  tick();
        step(0, 0, 0, 0, 1, 0, 1, 0, "hold1", 3, 0, 0, 2, 1);  tick();
        step(0, 0, 0, 0, 1, 0, 1, 0, "hold2", 3, 0, 0, 2, 1);  tick();
        step(1, 9, 1, 0, 1, 0, 0, 1, "flush", 3, 0, 0, 2, 1);  tick();
        step(0, 0, 0, 0, 9, 1, 0, 0, "post_flush_a", 0, 0, 0, 2, 1);
        step(0, 0, 0, 0, 3, 2, 0, 0, "post_flush_b", 2, 3, 0, 2, 1);
        idle(3);

        // Asynchronous reset during an active load-use stall
        step(1, 3, 1, 1, 0, 0, 0, 0, "rs_issue", 0, 0, 0, 2, 0);  tick();
        step(1, 11, 1, 0, 3, 0, 0, 0, "rs_stall", 1, 0, 1, 2, 1);
        rst = 1'b1;
        expect_out("rs_async", 0, 0, 0, 0, 0);
        #1;
        compare_out();
        #1 rst = 1'b0;
        idle(1);

        // Stall under hold does not count
        step(1, 3, 1, 1, 0, 0, 0, 0, "sh_issue", 0, 0, 0, 0, 0);  tick();
        step(1, 11, 1, 0, 3, 0, 1, 0, "sh_hold0", 1, 0, 1, 0, 1);  tick();
        step(1, 11, 1, 0, 3, 0, 1, 0, "sh_hold1", 1, 0, 1, 0, 1);  tick();
        step(1, 11, 1, 0, 3, 0, 0, 0, "sh_run",   1, 0, 1, 0, 1);  tick();
        step(1, 11, 1, 0, 3, 0, 0, 0, "sh_fwd",   2, 0, 0, 1, 1);
        idle(3);

        // Saturation on the narrow-counter instance: a stall every other edge
        sbus.fwd_id_valid_in   = 1'b1;
        sbus.fwd_id_rd_addr_in = 5'd3;
        sbus.fwd_id_rd_wen_in  = 1'b1;
        sbus.fwd_id_is_load_in = 1'b1;
        sbus.fwd_id_ra_addr_in = 5'd3;
        repeat (10) tick();
        check_sat("sat_mid", 4'd5);
        repeat (30) tick();
        check_sat("sat_full", 4'hF);
        repeat (4) tick();
        check_sat("sat_hold", 4'hF);

        if (sb.size() != 0) begin
            miscompares++;
            $error("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
